// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display. A frame-coherent shadow copy of the display value is stepped
// through one digit per slot. For every slot the block presents the digit's
// nibble and a decoder enable to a downstream hex-to-7-segment decoder and
// pulls the matching anode select low.
//
// Parameters
//   NUM_DIGITS   digits scanned (2..8)
//   REFRESH_DIV  clock cycles per digit slot (>= DEAD_CYCLES+1)
//   DEAD_CYCLES  cycles at the start of each slot with every anode off
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   digits_in   in   display value, digit k = [4k+3:4k], digit 0 rightmost
//   blank_in    in   per-digit blank request (1 = digit dark)
//   load        in   single-cycle strobe capturing digits_in / blank_in
//   data_out    out  nibble of the current digit (decoder data)
//   enable      out  decoder enable
//   digit_sel   out  active-low one-hot anode select
//   frame_done  out  high for the last cycle of each frame
// ---------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [3:0]              data_out,
    output logic                    enable,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]                 r_cnt;
    logic [IDX_W-1:0]                 r_idx;
    logic [NUM_DIGITS-1:0][3:0]       r_pend_d;
    logic [NUM_DIGITS-1:0]            r_pend_b;
    logic [NUM_DIGITS-1:0][3:0]       r_shad_d;
    logic [NUM_DIGITS-1:0]            r_shad_b;

    // -----------------------------------------------------------------------
    // Next-state values
    // -----------------------------------------------------------------------
    logic                             w_cnt_last;
    logic                             w_boundary;
    logic [CNT_W-1:0]                 w_cnt_nxt;
    logic [IDX_W-1:0]                 w_idx_nxt;
    logic [NUM_DIGITS-1:0][3:0]       w_pend_d_nxt;
    logic [NUM_DIGITS-1:0]            w_pend_b_nxt;
    logic [NUM_DIGITS-1:0][3:0]       w_shad_d_nxt;
    logic [NUM_DIGITS-1:0]            w_shad_b_nxt;

    // Output values computed from the next state so the registered outputs
    // line up with the state they describe in the same cycle.
    logic                             w_dead_nxt;
    logic                             w_en_nxt;
    logic [3:0]                       w_data_nxt;
    logic [NUM_DIGITS-1:0]            w_sel_nxt;
    logic                             w_fd_nxt;

    always_comb begin
        w_cnt_last = (r_cnt == CNT_LAST);
        w_boundary = w_cnt_last && (r_idx == IDX_LAST);

        w_cnt_nxt  = w_cnt_last ? '0 : r_cnt + 1'b1;
        w_idx_nxt  = r_idx;
        if (w_cnt_last) begin
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end

        w_pend_d_nxt = r_pend_d;
        w_pend_b_nxt = r_pend_b;
        if (load) begin
            w_pend_d_nxt = digits_in;
            w_pend_b_nxt = blank_in;
        end

        // The shadow copy only moves at the frame boundary; a load landing on
        // the boundary cycle is taken directly so it is not a frame late.
        w_shad_d_nxt = r_shad_d;
        w_shad_b_nxt = r_shad_b;
        if (w_boundary) begin
            w_shad_d_nxt = w_pend_d_nxt;
            w_shad_b_nxt = w_pend_b_nxt;
        end
    end

    // With no dead phase the compare against zero would be constant, so the
    // dead-phase detector is only built when it can be true.
    if (DEAD_CYCLES == 0) begin : g_no_dead
        assign w_dead_nxt = 1'b0;
    end else begin : g_dead
        assign w_dead_nxt = (w_cnt_nxt < DEAD_END);
    end

    always_comb begin
        w_data_nxt = w_shad_d_nxt[w_idx_nxt];
        w_en_nxt   = !w_dead_nxt && !w_shad_b_nxt[w_idx_nxt];
        w_fd_nxt   = (w_idx_nxt == IDX_LAST) && (w_cnt_nxt == CNT_LAST);

        // An anode is only ever pulled low together with the decoder enable;
        // a disabled decoder drives all segments on.
        w_sel_nxt = '1;
        if (w_en_nxt) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (w_idx_nxt == IDX_W'(i)) begin
                    w_sel_nxt[i] = 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_pend_d <= '0;
            r_pend_b <= '0;
            r_shad_d <= '0;
            r_shad_b <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_pend_d <= w_pend_d_nxt;
            r_pend_b <= w_pend_b_nxt;
            r_shad_d <= w_shad_d_nxt;
            r_shad_b <= w_shad_b_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            enable     <= 1'b0;
            digit_sel  <= '1;
            frame_done <= 1'b0;
        end else begin
            data_out   <= w_data_nxt;
            enable     <= w_en_nxt;
            digit_sel  <= w_sel_nxt;
            frame_done <= w_fd_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = ND * RD;

    logic            clk;
    logic            rst_n;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0]   blank_in;
    logic            load;
    logic [3:0]      data_out;
    logic            enable;
    logic [ND-1:0]   digit_sel;
    logic            frame_done;

    seg_scan_driver #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits_in (digits_in),
        .blank_in  (blank_in),
        .load      (load),
        .data_out  (data_out),
        .enable    (enable),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: time since reset release, the latest loaded value and
    // the value shown in the current frame.
    int            t;
    logic [15:0]   m_pend_d, m_shad_d;
    logic [3:0]    m_pend_b, m_shad_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 32'(data_out), 32'h0);
        check({tag, "_en"},   32'(enable), 32'h0);
        check({tag, "_sel"},  32'(digit_sel), 32'hF);
        check({tag, "_fd"},   32'(frame_done), 32'h0);
    endtask

    task automatic check_outputs();
        int k, c;
        logic [3:0] e_data, e_sel;
        logic e_en, e_fd;
        k = (t / RD) % ND;
        c = t % RD;
        if (t == 0) begin
            e_data = 4'h0; e_en = 1'b0; e_sel = 4'hF; e_fd = 1'b0;
        end else begin
            e_data = m_shad_d[4*k +: 4];
            e_en   = (c >= DC) && !m_shad_b[k];
            e_sel  = e_en ? ~(4'b0001 << k) : 4'hF;
            e_fd   = ((t % FRAME) == FRAME - 1);
        end
        check("data_out",   32'(data_out),   32'(e_data));
        check("enable",     32'(enable),     32'(e_en));
        check("digit_sel",  32'(digit_sel),  32'(e_sel));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("inv_sel_implies_en", 32'((digit_sel == 4'hF) || enable), 32'h1);
        check("inv_onehot", 32'($countones(~digit_sel) <= 1), 32'h1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (load) begin
            m_pend_d = digits_in;
            m_pend_b = blank_in;
        end
        t++;
        if (t % FRAME == 0) begin
            m_shad_d = m_pend_d;
            m_shad_b = m_pend_b;
        end
        #1;
        check_outputs();
    endtask

    task automatic run_to(input int k, input int c);
        int n;
        n = 0;
        while (!(((t / RD) % ND) == k && (t % RD) == c) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        check("run_to_reached", 32'((((t / RD) % ND) == k) && ((t % RD) == c)), 32'h1);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] b);
        digits_in = d;
        blank_in  = b;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; digits_in = '0; blank_in = '0;
        t = 0; m_pend_d = '0; m_pend_b = '0; m_shad_d = '0; m_shad_b = '0;

        // Reset / boot
        repeat (3) begin
            @(posedge clk); #1;
            check_reset_outputs("in_reset");
        end
        @(negedge clk); rst_n = 1'b1; t = 0;
        #1; check_outputs();
        repeat (2 * FRAME + 3) tick();

        // Coherent load: visible only from the next frame
        run_to(1, 3);
        pulse_load(16'h1234, 4'b0000);
        run_to(3, 4);
        check("coh_old_frame", 32'(data_out), 32'h0);
        run_to(0, 4); check("coh_s0_data", 32'(data_out), 32'h4); check("coh_s0_sel", 32'(digit_sel), 32'hE);
        run_to(1, 4); check("coh_s1_data", 32'(data_out), 32'h3); check("coh_s1_sel", 32'(digit_sel), 32'hD);
        run_to(2, 4); check("coh_s2_data", 32'(data_out), 32'h2); check("coh_s2_sel", 32'(digit_sel), 32'hB);
        run_to(3, 4); check("coh_s3_data", 32'(data_out), 32'h1); check("coh_s3_sel", 32'(digit_sel), 32'h7);

        // Mid-frame load does not tear the frame being shown
        run_to(1, 6);
        pulse_load(16'h5678, 4'b0000);
        run_to(2, 5); check("mid_s2_data", 32'(data_out), 32'h2);
        run_to(3, 5); check("mid_s3_data", 32'(data_out), 32'h1);
        run_to(0, 5); check("mid_n0_data", 32'(data_out), 32'h8);
        run_to(1, 5); check("mid_n1_data", 32'(data_out), 32'h7);
        run_to(2, 5); check("mid_n2_data", 32'(data_out), 32'h6);
        run_to(3, 5); check("mid_n3_data", 32'(data_out), 32'h5);

        // Load on the frame_done cycle takes effect at once
        run_to(3, 7);
        check("bnd_frame_done", 32'(frame_done), 32'h1);
        pulse_load(16'h9ABC, 4'b0000);
        check("bnd_s0_data_dead", 32'(data_out), 32'hC);
        check("bnd_s0_sel_dead", 32'(digit_sel), 32'hF);
        run_to(0, 3); check("bnd_s0_sel", 32'(digit_sel), 32'hE);

        // Blanking of digit 3
        pulse_load(16'h0123, 4'b1000);
        run_to(3, 0);
        run_to(0, 4); check("blk_s0_data", 32'(data_out), 32'h3);
        run_to(3, 4); check("blk_s3_sel", 32'(digit_sel), 32'hF); check("blk_s3_en", 32'(enable), 32'h0);
        run_to(1, 0);

        // Randomised loads and blanks
        for (int i = 0; i < 600; i++) begin
            digits_in = 16'($urandom);
            blank_in  = 4'($urandom);
            load      = (($urandom % 8) == 0);
            tick();
            load      = 1'b0;
        end

        // Asynchronous reset between edges
        blank_in = '0;
        run_to(2, 5);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (2) begin
            @(posedge clk); #1;
            check_reset_outputs("async_hold");
        end
        @(negedge clk); rst_n = 1'b1;
        t = 0; m_pend_d = '0; m_pend_b = '0; m_shad_d = '0; m_shad_b = '0;
        #1; check_outputs();
        repeat (FRAME + 4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
